fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-sequencing controller for the 16-bit stack CPU. It owns the program counter and instruction register and fetches 18-bit instructions from instruction memory over a req/ack handshake. It presents each instruction to the combinational control unit for an execute phase and applies taken jumps, datapath stalls and halt. It sits between instruction memory and the control unit/datapath and is the only block that advances the PC.

## Interface
Parameters:
- ADDR_W, 16, instruction-memory address / PC width
- INSTR_W, 18, instruction width, MSB-first bit ordering [0:INSTR_W-1]
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous active-high reset
- o_imemReq  out  1  fetch request to instruction memory
- o_imemAddr  out  ADDR_W  fetch address, equals PC while o_imemReq=1
- i_imemAck  in  1  memory returns i_imemData this cycle
- i_imemData  in  INSTR_W  fetched instruction, valid when i_imemAck=1
- o_instruction  out  INSTR_W  instruction register, drives control-unit i_instruction
- o_exec  out  1  execute phase; datapath commits only while 1
- i_stall  in  1  datapath needs another execute cycle
- i_jTaken  in  1  jump resolved taken (from jump logic)
- i_jTarget  in  ADDR_W  jump destination
- i_halt  in  1  halt request from datapath
- o_pc  out  ADDR_W  current PC (address of next fetch)
- o_halted  out  1  sequencer stopped

## Operation
- FSM states: S_IDLE, S_FETCH, S_EXEC, S_HALT. Moore outputs: o_imemReq=(S_FETCH), o_exec=(S_EXEC), o_halted=(S_HALT).
- Reset (any state): state<=S_IDLE, PC<=RESET_PC, IR<=0. Outputs during and right after reset: o_imemReq=0, o_exec=0, o_halted=0, o_instruction=0, o_pc=RESET_PC.
- S_IDLE: unconditional -> S_FETCH.
- S_FETCH: o_imemAddr=PC, held stable until ack. On i_imemAck: IR<=i_imemData, PC<=PC+1 (mod 2^ADDR_W, 16'hFFFF wraps to 0), -> S_EXEC. No ack: stay.
- S_EXEC: o_instruction stable. i_stall=1: hold all state, ignore i_jTaken/i_halt. Otherwise, priority: i_halt -> S_HALT, PC unchanged; else i_jTaken -> PC<=i_jTarget, -> S_FETCH; else -> S_FETCH.
- S_HALT: terminal until i_rst; all inputs ignored; IR and PC hold.
- i_imemAck outside S_FETCH is ignored (covers late acks after reset or jumps). i_jTaken/i_halt outside S_EXEC are ignored.

## Timing
- Zero-wait memory (ack in the request cycle): 2 cycles per instruction (FETCH, EXEC). Each memory wait cycle adds 1; each asserted stall cycle adds 1.
- First request is asserted in the 2nd cycle after i_rst deasserts (IDLE then FETCH).
- IR, PC and state update on the same edge that samples ack. o_exec rises the cycle after the ack.
- A taken jump loads PC on the edge leaving S_EXEC. The next cycle fetches i_jTarget, with no bubble beyond the normal FETCH.
- Reset mid-fetch: o_imemReq drops the cycle after reset is sampled; memory must tolerate an abandoned request.

## Structure
- Shared package cpu_pkg holds ADDR_W, INSTR_W, RESET_PC and the state enum (2-bit: IDLE=0, FETCH=1, EXEC=2, HALT=3).
- No sub-module. FSM, PC and IR live in one module, with the PC incrementer inline.

## Test plan
- Reset, then zero-wait memory holding 0x00001, 0x00002 at addresses 0,1 -> o_imemAddr 0 then 1; o_instruction=0x00001 with o_exec high 1 cycle, then 0x00002; 2 cycles per instruction.
- Memory with 3 wait cycles -> o_imemReq high 4 cycles, o_imemAddr stable, o_exec one cycle after ack.
- In EXEC at PC=5: i_jTaken=1, i_jTarget=0x0100 -> next o_imemAddr=0x0100. Same scenario with i_stall=1 for 2 cycles -> jump not taken until the stall releases; o_exec high 3 cycles.
- i_halt and i_jTaken asserted together in EXEC -> S_HALT, o_halted=1, o_pc unchanged, no further requests; i_rst -> o_pc=RESET_PC, o_halted=0.
- PC=0xFFFF fetch -> o_pc wraps to 0x0000; next fetch address 0x0000.
- i_rst asserted during a pending fetch, ack arriving 1 cycle later -> ack ignored, o_instruction=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit stack CPU.
//
// Holds the default address/instruction widths, the reset PC value and the
// fetch sequencer state encoding (IDLE=0, FETCH=1, EXEC=2, HALT=3).
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W   = 16;
    localparam int unsigned CPU_INSTR_W  = 18;
    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } seq_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_sequencer.sv
// Instruction-sequencing controller for the 16-bit stack CPU.
//
// Owns the program counter and the instruction register. Fetches one
// instruction over a req/ack handshake, presents it to the control unit for
// an execute phase, then applies stall, halt or a taken jump.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   o_imemReq      fetch request (high in FETCH)
//   o_imemAddr     fetch address, equals PC
//   i_imemAck      memory returns i_imemData this cycle (used in FETCH only)
//   i_imemData     fetched instruction
//   o_instruction  instruction register, to the control unit
//   o_exec         execute phase; datapath commits only while high
//   i_stall        datapath needs another execute cycle
//   i_jTaken       jump resolved taken (used in EXEC only)
//   i_jTarget      jump destination
//   i_halt         halt request (used in EXEC only, wins over a jump)
//   o_pc           current PC (address of the next fetch)
//   o_halted       sequencer stopped until reset
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_W   = CPU_ADDR_W,
    parameter int unsigned           INSTR_W  = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0]     RESET_PC = CPU_RESET_PC
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_imemReq,
    output logic [ADDR_W-1:0]    o_imemAddr,
    input  logic                 i_imemAck,
    input  logic [0:INSTR_W-1]   i_imemData,
    output logic [0:INSTR_W-1]   o_instruction,
    output logic                 o_exec,
    input  logic                 i_stall,
    input  logic                 i_jTaken,
    input  logic [ADDR_W-1:0]    i_jTarget,
    input  logic                 i_halt,
    output logic [ADDR_W-1:0]    o_pc,
    output logic                 o_halted
);

    seq_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [0:INSTR_W-1]   ir_q, ir_d;

    // Next-state logic. Every register holds by default, so a stalled EXEC
    // and the HALT state need no explicit assignments.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (i_imemAck) begin
                    ir_d    = i_imemData;
                    // Natural wrap of the ADDR_W-bit adder: all-ones -> 0.
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (!i_stall) begin
                    if (i_halt) begin
                        state_d = S_HALT;
                    end else if (i_jTaken) begin
                        pc_d    = i_jTarget;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Moore outputs.
    assign o_imemReq     = (state_q == S_FETCH);
    assign o_exec        = (state_q == S_EXEC);
    assign o_halted      = (state_q == S_HALT);
    assign o_imemAddr    = pc_q;
    assign o_pc          = pc_q;
    assign o_instruction = ir_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of per-cycle input/expected
// output records plus a short hand-written reset-to-first-request sequence.
module tb_fetch_sequencer;

    logic         clk;
    logic         rst;
    logic         imem_req;
    logic [15:0]  imem_addr;
    logic         imem_ack;
    logic [0:17]  imem_data;
    logic [0:17]  instruction;
    logic         exec;
    logic         stall;
    logic         j_taken;
    logic [15:0]  j_target;
    logic         halt;
    logic [15:0]  pc;
    logic         halted;

    int unsigned n_checks;
    int unsigned n_errors;

    fetch_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imemReq     (imem_req),
        .o_imemAddr    (imem_addr),
        .i_imemAck     (imem_ack),
        .i_imemData    (imem_data),
        .o_instruction (instruction),
        .o_exec        (exec),
        .i_stall       (stall),
        .i_jTaken      (j_taken),
        .i_jTarget     (j_target),
        .i_halt        (halt),
        .o_pc          (pc),
        .o_halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied during a cycle; outputs expected in that same cycle
    // (they reflect the state entered on the previous edge).
    typedef struct {
        logic         rst;
        logic         ack;
        logic [17:0]  data;
        logic         stall;
        logic         jt;
        logic [15:0]  tgt;
        logic         halt;
        logic         e_req;
        logic [15:0]  e_addr;
        logic         e_exec;
        logic [17:0]  e_instr;
        logic [15:0]  e_pc;
        logic         e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic a, input logic [17:0] d,
                                input logic s, input logic j, input logic [15:0] t,
                                input logic h, input logic ereq, input logic [15:0] eaddr,
                                input logic eexec, input logic [17:0] einstr,
                                input logic [15:0] epc, input logic ehalt);
        vec_t v;
        v.rst = r; v.ack = a; v.data = d; v.stall = s; v.jt = j; v.tgt = t; v.halt = h;
        v.e_req = ereq; v.e_addr = eaddr; v.e_exec = eexec; v.e_instr = einstr;
        v.e_pc = epc; v.e_halted = ehalt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        imem_ack  = v.ack;
        imem_data = v.data;
        stall     = v.stall;
        j_taken   = v.jt;
        j_target  = v.tgt;
        halt      = v.halt;
    endtask

    initial begin
        int waited;
        rst = 1'b1; imem_ack = 1'b0; imem_data = '0; stall = 1'b0;
        j_taken = 1'b0; j_target = '0; halt = 1'b0;
        n_checks = 0; n_errors = 0;

        //          rst ack data     stl jt tgt      hlt req addr     ex instr    pc       hlt
        // Reset, then zero-wait fetches of 0x00001 / 0x00002.
        vecs.push_back(mk(1, 0, 18'h0,     0, 0, 16'h0,    0, 0, 16'h0000, 0, 18'h0,     16'h0000, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 0, 16'h0000, 0, 18'h0,     16'h0000, 0));
        vecs.push_back(mk(0, 1, 18'h00001, 0, 0, 16'h0,    0, 1, 16'h0000, 0, 18'h0,     16'h0000, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 0, 16'h0001, 1, 18'h00001, 16'h0001, 0));
        vecs.push_back(mk(0, 1, 18'h00002, 0, 0, 16'h0,    0, 1, 16'h0001, 0, 18'h00001, 16'h0001, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 0, 16'h0002, 1, 18'h00002, 16'h0002, 0));
        // Three wait cycles; jump/halt during FETCH are ignored.
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 16'h0055, 0, 1, 16'h0002, 0, 18'h00002, 16'h0002, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    1, 1, 16'h0002, 0, 18'h00002, 16'h0002, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 1, 16'h0002, 0, 18'h00002, 16'h0002, 0));
        vecs.push_back(mk(0, 1, 18'h00003, 0, 0, 16'h0,    0, 1, 16'h0002, 0, 18'h00002, 16'h0002, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 0, 16'h0003, 1, 18'h00003, 16'h0003, 0));
        // Walk to PC=5, then a taken jump to 0x0100.
        vecs.push_back(mk(0, 1, 18'h00004, 0, 0, 16'h0,    0, 1, 16'h0003, 0, 18'h00003, 16'h0003, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 0, 16'h0004, 1, 18'h00004, 16'h0004, 0));
        vecs.push_back(mk(0, 1, 18'h00005, 0, 0, 16'h0,    0, 1, 16'h0004, 0, 18'h00004, 16'h0004, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 16'h0100, 0, 0, 16'h0005, 1, 18'h00005, 16'h0005, 0));
        vecs.push_back(mk(0, 1, 18'h00006, 0, 0, 16'h0,    0, 1, 16'h0100, 0, 18'h00005, 16'h0100, 0));
        // Jump held off by a two-cycle stall (halt also ignored while stalled).
        vecs.push_back(mk(0, 0, 18'h0,     1, 1, 16'h0200, 1, 0, 16'h0101, 1, 18'h00006, 16'h0101, 0));
        vecs.push_back(mk(0, 0, 18'h0,     1, 1, 16'h0200, 0, 0, 16'h0101, 1, 18'h00006, 16'h0101, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 16'h0200, 0, 0, 16'h0101, 1, 18'h00006, 16'h0101, 0));
        vecs.push_back(mk(0, 1, 18'h00007, 0, 0, 16'h0,    0, 1, 16'h0200, 0, 18'h00006, 16'h0200, 0));
        // Halt beats jump; HALT ignores everything until reset.
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 16'h0300, 1, 0, 16'h0201, 1, 18'h00007, 16'h0201, 0));
        vecs.push_back(mk(0, 1, 18'h00009, 0, 1, 16'h0300, 0, 0, 16'h0201, 0, 18'h00007, 16'h0201, 1));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    1, 0, 16'h0201, 0, 18'h00007, 16'h0201, 1));
        vecs.push_back(mk(1, 0, 18'h0,     0, 0, 16'h0,    0, 0, 16'h0201, 0, 18'h00007, 16'h0201, 1));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 0, 16'h0000, 0, 18'h0,     16'h0000, 0));
        // PC wrap: jump to 0xFFFF, fetch there, next fetch address is 0.
        vecs.push_back(mk(0, 1, 18'h3FFFF, 0, 0, 16'h0,    0, 1, 16'h0000, 0, 18'h0,     16'h0000, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 16'hFFFF, 0, 0, 16'h0001, 1, 18'h3FFFF, 16'h0001, 0));
        vecs.push_back(mk(0, 1, 18'h12345, 0, 0, 16'h0,    0, 1, 16'hFFFF, 0, 18'h3FFFF, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 1, 16'h0040, 0, 0, 16'h0000, 1, 18'h12345, 16'h0000, 0));
        // Reset during a pending fetch; the late ack must be ignored.
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 1, 16'h0040, 0, 18'h12345, 16'h0040, 0));
        vecs.push_back(mk(1, 0, 18'h0,     0, 0, 16'h0,    0, 1, 16'h0040, 0, 18'h12345, 16'h0040, 0));
        vecs.push_back(mk(0, 1, 18'h2AAAA, 0, 0, 16'h0,    0, 0, 16'h0000, 0, 18'h0,     16'h0000, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 1, 16'h0000, 0, 18'h0,     16'h0000, 0));
        vecs.push_back(mk(0, 1, 18'h00011, 0, 0, 16'h0,    0, 1, 16'h0000, 0, 18'h0,     16'h0000, 0));
        vecs.push_back(mk(0, 0, 18'h0,     0, 0, 16'h0,    0, 0, 16'h0001, 1, 18'h00011, 16'h0001, 0));

        // Initial reset so the first table row starts from a known state.
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            chk("imem_req",    i, 32'(imem_req),    32'(vecs[i].e_req));
            chk("imem_addr",   i, 32'(imem_addr),   32'(vecs[i].e_addr));
            chk("exec",        i, 32'(exec),        32'(vecs[i].e_exec));
            chk("instruction", i, 32'(instruction), 32'(vecs[i].e_instr));
            chk("pc",          i, 32'(pc),          32'(vecs[i].e_pc));
            chk("halted",      i, 32'(halted),      32'(vecs[i].e_halted));
            @(posedge clk);
            #1;
        end

        // Reset out of EXEC; first request must appear in the 2nd cycle after
        // reset deasserts, addressed at the reset PC.
        imem_ack = 1'b0; stall = 1'b0; j_taken = 1'b0; halt = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        waited = 1;
        #2;
        while (!imem_req && waited < 8) begin
            @(posedge clk); #3;
            waited++;
        end
        chk("first_req_cycle", -1, 32'(waited), 32'd2);
        chk("first_req_addr",  -1, 32'(imem_addr), 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fetch_sequencer
